// File: rtl/debug_trace_fifo.sv
// Trace capture: bus writes to channel windows are timestamped and queued; CTRL sets mask/clears drops; HALT flushes.
// Latency: capture visible on rec_* one cycle after the write is sampled; level/drop update the same edge.
// Backpressure: rec_ready_i low holds the head record stable; a full FIFO drops captures unless a pop frees a slot.
module trace_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_acc;
    logic             pop_acc;

    assign pop_vld  = (level != '0);
    assign pop_acc  = pop_vld & pop_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign push_rdy = (level != LW'(DEPTH)) | pop_acc;
    assign push_acc = push_vld & push_rdy;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_acc, pop_acc})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

module debug_trace_fifo #(
    parameter int          DATA_WIDTH = 32,
    parameter int          TS_WIDTH   = 64,
    parameter int          CHANNELS   = 4,
    parameter int          DEPTH      = 16,
    parameter int          DROP_WIDTH = 16,
    parameter logic [23:0] BASE_ADDR  = 24'h000100,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [23:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [TS_WIDTH-1:0]   tick_cntr_i,
    output logic                  rec_valid_o,
    input  logic                  rec_ready_i,
    output logic [CW-1:0]         rec_chan_o,
    output logic [DATA_WIDTH-1:0] rec_data_o,
    output logic [TS_WIDTH-1:0]   rec_ts_o,
    output logic [LW-1:0]         level_o,
    output logic [DROP_WIDTH-1:0] drop_cnt_o,
    output logic                  halt_o
);
    typedef struct packed {
        logic [CW-1:0]         chan;
        logic [DATA_WIDTH-1:0] dat;
        logic [TS_WIDTH-1:0]   ts;
    } rec_t;

    typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

    localparam logic [23:0] CTRL_ADDR = BASE_ADDR + 24'(4 * CHANNELS);
    localparam logic [23:0] HALT_ADDR = BASE_ADDR + 24'(4 * CHANNELS + 4);

    state_t              state, state_nxt;
    logic [CHANNELS-1:0] mask;
    logic                wr;
    logic                chan_hit;
    logic [CW-1:0]       chan_sel;
    logic                cap;
    logic                push_vld;
    logic                push_rdy;
    logic                drop;
    logic                clr;
    rec_t                push_rec;
    rec_t                head_rec;

    assign wr = en_i & we_i;

    always_comb begin
        chan_hit = 1'b0;
        chan_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (addr_i == BASE_ADDR + 24'(4 * c)) begin
                chan_hit = 1'b1;
                chan_sel = CW'(c);
            end
        end
    end

    assign cap      = wr & chan_hit & (state == RUN);
    assign push_vld = cap & mask[chan_sel];
    assign drop     = cap & (~mask[chan_sel] | ~push_rdy);
    assign clr      = wr & (addr_i == CTRL_ADDR) & data_i[DATA_WIDTH-1];

    assign push_rec.chan = chan_sel;
    assign push_rec.dat  = data_i;
    assign push_rec.ts   = tick_cntr_i;

    trace_sync_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (push_vld),
        .push_rdy (push_rdy),
        .push_dat (push_rec),
        .pop_vld  (rec_valid_o),
        .pop_rdy  (rec_ready_i),
        .pop_dat  (head_rec),
        .level    (level_o)
    );

    assign rec_chan_o = head_rec.chan;
    assign rec_data_o = head_rec.dat;
    assign rec_ts_o   = head_rec.ts;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask       <= '1;
            drop_cnt_o <= '0;
        end else begin
            if (wr && addr_i == CTRL_ADDR) mask <= data_i[CHANNELS-1:0];
            if (clr) begin
                drop_cnt_o <= '0;
            end else if (drop && drop_cnt_o != '1) begin
                drop_cnt_o <= drop_cnt_o + DROP_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= RUN;
        else       state <= state_nxt;
    end

    // No pop can be in progress once level is zero, so empty alone ends the flush.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (wr && addr_i == HALT_ADDR) state_nxt = FLUSH;
            FLUSH:   if (level_o == '0) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        halt_o = (state == HALTED);
    end
endmodule

// File: tb/tb_debug_trace_fifo.sv
module tb_debug_trace_fifo;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i = 1'b0;
    logic        we_i = 1'b0;
    logic [23:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [63:0] tick_cntr_i = '0;
    logic        rec_valid_o;
    logic        rec_ready_i = 1'b0;
    logic [1:0]  rec_chan_o;
    logic [31:0] rec_data_o;
    logic [63:0] rec_ts_o;
    logic [4:0]  level_o;
    logic [15:0] drop_cnt_o;
    logic        halt_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    debug_trace_fifo dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .tick_cntr_i (tick_cntr_i),
        .rec_valid_o (rec_valid_o),
        .rec_ready_i (rec_ready_i),
        .rec_chan_o  (rec_chan_o),
        .rec_data_o  (rec_data_o),
        .rec_ts_o    (rec_ts_o),
        .level_o     (level_o),
        .drop_cnt_o  (drop_cnt_o),
        .halt_o      (halt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d, input logic [63:0] ts);
        en_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d; tick_cntr_i = ts;
        step();
        en_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", 64'(rec_valid_o), 64'd0);
        chk("rst_level", 64'(level_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        chk("rst_halt", 64'(halt_o), 64'd0);

        // Single capture on channel 2
        wr(24'h108, 32'hCAFE, 64'd100);
        chk("single_valid", 64'(rec_valid_o), 64'd1);
        chk("single_chan", 64'(rec_chan_o), 64'd2);
        chk("single_data", 64'(rec_data_o), 64'hCAFE);
        chk("single_ts", 64'(rec_ts_o), 64'd100);
        chk("single_level", 64'(level_o), 64'd1);
        step();
        step();
        chk("hold_valid", 64'(rec_valid_o), 64'd1);
        chk("hold_data", 64'(rec_data_o), 64'hCAFE);
        chk("hold_ts", 64'(rec_ts_o), 64'd100);
        rec_ready_i = 1'b1;
        step();
        rec_ready_i = 1'b0;
        chk("single_pop_valid", 64'(rec_valid_o), 64'd0);
        chk("single_pop_level", 64'(level_o), 64'd0);

        // Overflow: 20 captures into 16 entries
        for (int i = 0; i < 20; i++) wr(24'h100, 32'(i), 64'(200 + i));
        chk("ovf_level", 64'(level_o), 64'd16);
        chk("ovf_drop", 64'(drop_cnt_o), 64'd4);
        rec_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ovf_drain_valid", 64'(rec_valid_o), 64'd1);
            chk("ovf_drain_data", 64'(rec_data_o), 64'(i));
            chk("ovf_drain_ts", rec_ts_o, 64'(200 + i));
            step();
        end
        rec_ready_i = 1'b0;
        chk("ovf_empty_valid", 64'(rec_valid_o), 64'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) wr(24'h100, 32'h100 + 32'(i), 64'(300 + i));
        chk("full_level", 64'(level_o), 64'd16);
        rec_ready_i = 1'b1;
        wr(24'h100, 32'h1FF, 64'd400);
        rec_ready_i = 1'b0;
        chk("full_pp_drop", 64'(drop_cnt_o), 64'd4);
        chk("full_pp_level", 64'(level_o), 64'd16);
        rec_ready_i = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("full_drain_data", 64'(rec_data_o), 64'h100 + 64'(i));
            step();
        end
        chk("full_tail_data", 64'(rec_data_o), 64'h1FF);
        chk("full_tail_ts", rec_ts_o, 64'd400);
        step();
        rec_ready_i = 1'b0;
        chk("full_drained", 64'(level_o), 64'd0);

        // Mask and clear
        wr(24'h110, 32'h8000_000F, 64'd0);
        chk("clr_drop", 64'(drop_cnt_o), 64'd0);
        wr(24'h110, 32'h1, 64'd0);
        wr(24'h104, 32'hAA, 64'd500);
        chk("mask_drop", 64'(drop_cnt_o), 64'd1);
        chk("mask_nopush", 64'(level_o), 64'd0);
        wr(24'h100, 32'hBB, 64'd501);
        chk("mask_ch0_level", 64'(level_o), 64'd1);
        chk("mask_ch0_data", 64'(rec_data_o), 64'hBB);
        chk("mask_ch0_drop", 64'(drop_cnt_o), 64'd1);
        wr(24'h110, 32'h8000_000F, 64'd0);
        chk("mask_clr_drop", 64'(drop_cnt_o), 64'd0);
        rec_ready_i = 1'b1;
        step();
        rec_ready_i = 1'b0;

        // Flush then halt
        for (int i = 0; i < 3; i++) wr(24'h100, 32'h30 + 32'(i), 64'(600 + i));
        wr(24'h114, 32'h0, 64'd0);
        chk("flush_halt0", 64'(halt_o), 64'd0);
        wr(24'h100, 32'h99, 64'd700);
        wr(24'h10C, 32'h98, 64'd701);
        chk("flush_drop", 64'(drop_cnt_o), 64'd0);
        chk("flush_level", 64'(level_o), 64'd3);
        chk("flush_halt1", 64'(halt_o), 64'd0);
        rec_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("flush_pop_data", 64'(rec_data_o), 64'h30 + 64'(i));
            step();
        end
        rec_ready_i = 1'b0;
        chk("flush_level0", 64'(level_o), 64'd0);
        chk("flush_halt_early", 64'(halt_o), 64'd0);
        step();
        chk("halted", 64'(halt_o), 64'd1);
        wr(24'h114, 32'h0, 64'd0);
        wr(24'h100, 32'h77, 64'd800);
        chk("halted_sticky", 64'(halt_o), 64'd1);
        chk("halted_nocap", 64'(level_o), 64'd0);

        // Reset mid-stream in FLUSH with 5 queued
        do_reset();
        for (int i = 0; i < 5; i++) wr(24'h100, 32'(i), 64'(900 + i));
        wr(24'h114, 32'h0, 64'd0);
        chk("pre_rst_level", 64'(level_o), 64'd5);
        do_reset();
        chk("mid_rst_valid", 64'(rec_valid_o), 64'd0);
        chk("mid_rst_level", 64'(level_o), 64'd0);
        chk("mid_rst_drop", 64'(drop_cnt_o), 64'd0);
        chk("mid_rst_halt", 64'(halt_o), 64'd0);
        wr(24'h108, 32'hCAFE, 64'd100);
        chk("post_rst_valid", 64'(rec_valid_o), 64'd1);
        chk("post_rst_chan", 64'(rec_chan_o), 64'd2);
        chk("post_rst_data", 64'(rec_data_o), 64'hCAFE);
        chk("post_rst_ts", rec_ts_o, 64'd100);
        chk("post_rst_level", 64'(level_o), 64'd1);
        step();
        chk("post_rst_halt", 64'(halt_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
